// File: rtl/mhp_rx_parser.sv
// rtl/mhp_rx_parser.sv - MHP receive parser: header capture, address filter, payload stream, frame status
// Checksum verification is built only when MHP_RX_CSUM_EN is defined.
module mhp_rx_parser #(
  parameter logic [15:0] MY_ADDR     = 16'h0001,
  parameter int          MAX_PAYLOAD = 512,
  parameter int          GAP_CYCLES  = 62
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rdata,
  input  logic        i_rready,
  output logic        o_rreq,
  input  logic        i_pready,
  output logic [7:0]  o_pdata,
  output logic        o_pvalid,
  output logic [15:0] o_dst,
  output logic [15:0] o_src,
  output logic [15:0] o_size,
  output logic        o_dir,
  output logic [6:0]  o_type,
  output logic        o_hdr_valid,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CHECK,
    S_DISCARD
  } state_t;

  localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES - 1);

  state_t      state;
  logic        rd_vld;
  logic [9:0]  cnt;
  logic [5:0]  gap_cnt;
  logic        addr_ok;
`ifdef MHP_RX_CSUM_EN
  logic [15:0] csum;
  logic [7:0]  scs_hi;
  logic [7:0]  scs_lo;
`endif

  logic rd_busy;
  logic can_read;
  logic gap_step;
  logic gap_hit;

  // A read is outstanding from the strobe cycle until its byte is captured.
  assign rd_busy = o_rreq | rd_vld;

  always_comb begin
    can_read = 1'b0;
    gap_step = 1'b0;
    case (state)
      S_HDR, S_DISCARD: begin
        can_read = i_rready & ~rd_busy;
        gap_step = ~rd_vld;
      end
      S_PAYLOAD: begin
        can_read = i_rready & i_pready & ~rd_busy;
        gap_step = ~rd_vld & i_pready;
      end
      default: begin
        can_read = 1'b0;
        gap_step = 1'b0;
      end
    endcase
  end

  assign gap_hit = gap_step && (gap_cnt == GAP_LAST);
  assign o_busy  = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      o_rreq      <= 1'b0;
      rd_vld      <= 1'b0;
      cnt         <= 10'd0;
      gap_cnt     <= 6'd0;
      addr_ok     <= 1'b0;
      o_pdata     <= 8'h00;
      o_pvalid    <= 1'b0;
      o_dst       <= 16'h0000;
      o_src       <= 16'h0000;
      o_size      <= 16'h0000;
      o_dir       <= 1'b0;
      o_type      <= 7'd0;
      o_hdr_valid <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= 2'd0;
`ifdef MHP_RX_CSUM_EN
      csum        <= 16'h0000;
      scs_hi      <= 8'h00;
      scs_lo      <= 8'h00;
`endif
    end else begin
      o_rreq      <= 1'b0;
      o_pvalid    <= 1'b0;
      o_hdr_valid <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      rd_vld      <= o_rreq;

      case (state)
        S_IDLE: begin
          cnt     <= 10'd0;
          gap_cnt <= 6'd0;
`ifdef MHP_RX_CSUM_EN
          csum    <= 16'h0000;
`endif
          if (i_rready) begin
            o_rreq <= 1'b1;
            state  <= S_HDR;
          end
        end

        S_HDR, S_PAYLOAD, S_DISCARD: begin
          if (can_read && !gap_hit) o_rreq <= 1'b1;
          if (rd_vld) begin
            gap_cnt <= 6'd0;
            cnt     <= cnt + 10'd1;
`ifdef MHP_RX_CSUM_EN
            if ((state == S_HDR && cnt < 10'd7) || state == S_PAYLOAD)
              csum <= csum + {8'h00, i_rdata};
`endif
            if (state == S_HDR) begin
              case (cnt[3:0])
                4'd0: o_dst[15:8] <= i_rdata;
                4'd1: begin
                  o_dst[7:0] <= i_rdata;
                  addr_ok    <= ({o_dst[15:8], i_rdata} == MY_ADDR) ||
                                ({o_dst[15:8], i_rdata} == 16'hFFFF);
                end
                4'd2: o_src[15:8] <= i_rdata;
                4'd3: o_src[7:0]  <= i_rdata;
                4'd4: o_size[15:8] <= i_rdata;
                4'd5: o_size[7:0]  <= i_rdata;
                4'd6: begin
                  o_dir  <= i_rdata[7];
                  o_type <= i_rdata[6:0];
                end
`ifdef MHP_RX_CSUM_EN
                4'd7: scs_hi <= i_rdata;
                4'd8: scs_lo <= i_rdata;
`endif
                default: ;
              endcase
              // Header complete: size decides where the frame goes next.
              if (cnt == 10'd8) begin
                o_hdr_valid <= 1'b1;
                cnt         <= 10'd0;
                if (o_size > 16'(MAX_PAYLOAD))
                  state <= S_DISCARD;
                else if (o_size == 16'h0000)
                  state <= S_CHECK;
                else
                  state <= S_PAYLOAD;
              end
            end else if (state == S_PAYLOAD) begin
              o_pdata  <= i_rdata;
              o_pvalid <= addr_ok;
              if ((cnt + 10'd1) == o_size[9:0]) state <= S_CHECK;
            end
          end else if (gap_hit) begin
            o_frame_err <= 1'b1;
            o_err_code  <= (state == S_DISCARD) ? 2'd3 : 2'd2;
            state       <= S_IDLE;
          end else if (gap_step) begin
            gap_cnt <= gap_cnt + 6'd1;
          end
        end

        S_CHECK: begin
          state <= S_IDLE;
          if (!addr_ok) begin
            o_frame_err <= 1'b1;
            o_err_code  <= 2'd1;
          end else begin
`ifdef MHP_RX_CSUM_EN
            if (csum != {scs_hi, scs_lo}) begin
              o_frame_err <= 1'b1;
              o_err_code  <= 2'd0;
            end else begin
              o_frame_ok <= 1'b1;
            end
`else
            o_frame_ok <= 1'b1;
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
